// File: rtl/mem_copy_engine_if.sv
// Data-memory initiator bundle for mem_copy_engine: request operands, status and memory port.
// The checksum signal exists only when MEMCPY_CHECKSUM_EN is defined.
interface mem_copy_engine_if #(
    parameter int LEN_W = 11
);
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [1:0]       MEM;
    logic [31:0]      Addr;
    logic [31:0]      Wdata;
    logic [31:0]      Rdata;
`ifdef MEMCPY_CHECKSUM_EN
    logic [31:0]      checksum;

    modport master (
        input  start, src_addr, dst_addr, len, Rdata,
        output busy, done, MEM, Addr, Wdata, checksum
    );

    modport slave (
        output start, src_addr, dst_addr, len, Rdata,
        input  busy, done, MEM, Addr, Wdata, checksum
    );
`else
    modport master (
        input  start, src_addr, dst_addr, len, Rdata,
        output busy, done, MEM, Addr, Wdata
    );

    modport slave (
        output start, src_addr, dst_addr, len, Rdata,
        input  busy, done, MEM, Addr, Wdata
    );
`endif
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: one read cycle then one write cycle per word, one-cycle done pulse.
// Optional running sum of read data is enabled by defining MEMCPY_CHECKSUM_EN.
module mem_copy_engine #(
    parameter int LEN_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_copy_engine_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] i;
    logic [31:0]      buf_q;
`ifdef MEMCPY_CHECKSUM_EN
    logic [31:0]      sum_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            i     <= '0;
            buf_q <= '0;
`ifdef MEMCPY_CHECKSUM_EN
            sum_q <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_q <= bus.src_addr;
                        dst_q <= bus.dst_addr;
                        len_q <= bus.len;
                        i     <= '0;
`ifdef MEMCPY_CHECKSUM_EN
                        sum_q <= '0;
`endif
                    end
                end
                READ: begin
                    buf_q <= bus.Rdata;
`ifdef MEMCPY_CHECKSUM_EN
                    sum_q <= sum_q + bus.Rdata;
`endif
                end
                WRITE: i <= i + LEN_W'(1);
                default: ;
            endcase
        end
    end

    // Outputs decode from the registered state only, so start never reaches MEM combinationally.
    always_comb begin
        state_nx  = state;
        bus.busy  = (state != IDLE);
        bus.done  = 1'b0;
        bus.MEM   = 2'b00;
        bus.Addr  = '0;
        bus.Wdata = '0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = (bus.len == '0) ? DONE : READ;
            end
            READ: begin
                bus.MEM  = 2'b10;
                bus.Addr = src_q + 32'(i);
                state_nx = WRITE;
            end
            WRITE: begin
                bus.MEM   = 2'b01;
                bus.Addr  = dst_q + 32'(i);
                bus.Wdata = buf_q;
                state_nx  = (i == len_q - LEN_W'(1)) ? DONE : READ;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef MEMCPY_CHECKSUM_EN
    assign bus.checksum = sum_q;
`endif
endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: table of copies plus reset, zero-length, wrap and abort sequences.
module tb_mem_copy_engine;
    localparam int LEN_W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_copy_engine_if #(.LEN_W(LEN_W)) bus ();

    mem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // 1024-word memory, only Addr[9:0] decoded; bench preload shares the single write process
    logic [31:0] mem [1024];
    logic        fill_en = 1'b0;
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'hA5A5_0000 + 32'(k);
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.MEM[0]) begin
            mem[bus.Addr[9:0]] <= bus.Wdata;
        end
    end

    assign bus.Rdata = bus.MEM[1] ? mem[bus.Addr[9:0]] : 32'h0;

    typedef struct {
        logic [31:0]      src;
        logic [31:0]      dst;
        logic [LEN_W-1:0] len;
        logic [31:0]      mul;
        int               inj;
        int               lat;
        logic [31:0]      first;
        logic [31:0]      last;
        logic [31:0]      after;
        logic [31:0]      sum;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fill();
        @(negedge clk) fill_en = 1'b1;
        @(negedge clk) fill_en = 1'b0;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a[9:0];
        pl_data = d;
        @(negedge clk) pl_we = 1'b0;
    endtask

    // inj>0: stray start with other operands at that cycle; inj<0: stray start during DONE
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [LEN_W-1:0] len, input int inj, output int lat);
        int mem_cycles;
        int bad;
        mem_cycles = 0;
        bad = 0;
        lat = -1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = src;
        bus.dst_addr = dst;
        bus.len      = len;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.MEM == 2'b11 || !bus.busy) bad++;
            if (bus.MEM != 2'b00) mem_cycles++;
            if (bus.done) begin
                lat = k;
                if (inj < 0) begin
                    bus.start    = 1'b1;
                    bus.src_addr = 32'd900;
                    bus.dst_addr = 32'd950;
                    bus.len      = LEN_W'(2);
                end
                break;
            end
            if (k == inj) begin
                bus.start    = 1'b1;
                bus.src_addr = 32'd900;
                bus.dst_addr = 32'd950;
                bus.len      = LEN_W'(2);
            end
        end
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout actual=none required=done within 3000 cycles");
        end
        chk("busy_and_mem_legal", 32'(bad), 32'd0);
        chk("mem_cycles", 32'(mem_cycles), 32'(2 * int'(len)));
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy || bus.done || bus.MEM != 2'b00) bad++;
        end
        chk("idle_after_done", 32'(bad), 32'd0);
    endtask

    initial begin
        int          lat;
        int          bad;
        logic [31:0] t;

        vecs[0] = '{32'd4,   32'd100,        LEN_W'(3), 32'h11,   0,  7,  32'h11,   32'h33,   32'hA5A5_0067, 32'h66};
        vecs[1] = '{32'd200, 32'd300,        LEN_W'(1), 32'h1234, 1,  3,  32'h1234, 32'h1234, 32'hA5A5_012D, 32'h1234};
        vecs[2] = '{32'd10,  32'd500,        LEN_W'(5), 32'h100,  2,  11, 32'h100,  32'h500,  32'hA5A5_01F9, 32'hF00};
        vecs[3] = '{32'd64,  32'hFFFF_FFFE,  LEN_W'(2), 32'h7,    -1, 5,  32'h7,    32'hE,    32'hA5A5_0000, 32'h15};

        // reset held with start asserted
        bus.start    = 1'b1;
        bus.src_addr = 32'd4;
        bus.dst_addr = 32'd100;
        bus.len      = LEN_W'(3);
        rst_n        = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_mem",  32'(bus.MEM),  32'd0);
            chk("rst_addr", bus.Addr,      32'd0);
        end
`ifdef MEMCPY_CHECKSUM_EN
        chk("rst_checksum", bus.checksum, 32'd0);
`endif
        bus.start = 1'b0;
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            fill();
            for (int k = 0; k < int'(vecs[v].len); k++)
                poke(vecs[v].src + 32'(k), vecs[v].mul * 32'(k + 1));
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].inj, lat);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            t = vecs[v].dst;
            chk($sformatf("v%0d_first", v), mem[t[9:0]], vecs[v].first);
            t = vecs[v].dst + 32'(vecs[v].len) - 32'd1;
            chk($sformatf("v%0d_last", v), mem[t[9:0]], vecs[v].last);
            t = vecs[v].dst + 32'(vecs[v].len);
            chk($sformatf("v%0d_after", v), mem[t[9:0]], vecs[v].after);
`ifdef MEMCPY_CHECKSUM_EN
            chk($sformatf("v%0d_checksum", v), bus.checksum, vecs[v].sum);
`endif
        end

        // zero length: done next cycle, no traffic
        fill();
        run_copy(32'd20, 32'd40, LEN_W'(0), 0, lat);
        chk("zero_latency", 32'(lat), 32'd1);
        chk("zero_dst_untouched", mem[40], 32'hA5A5_0028);
`ifdef MEMCPY_CHECKSUM_EN
        chk("zero_checksum", bus.checksum, 32'd0);
`endif

        // wrap at word 1024 with forward propagation into the destination
        fill();
        poke(32'd1022, 32'hAAAA_0001);
        poke(32'd1023, 32'hBBBB_0002);
        poke(32'd0,    32'hCCCC_0003);
        poke(32'd1,    32'hDDDD_0004);
        run_copy(32'd1022, 32'd0, LEN_W'(4), 0, lat);
        chk("wrap_latency", 32'(lat), 32'd9);
        chk("wrap_d0", mem[0], 32'hAAAA_0001);
        chk("wrap_d1", mem[1], 32'hBBBB_0002);
        chk("wrap_d2", mem[2], 32'hAAAA_0001);
        chk("wrap_d3", mem[3], 32'hBBBB_0002);
`ifdef MEMCPY_CHECKSUM_EN
        chk("wrap_checksum", bus.checksum, 32'hCCCA_0006);
`endif

        // abort: reset for one cycle during the third read
        fill();
        for (int k = 0; k < 8; k++) poke(32'd600 + 32'(k), 32'd3 * 32'(k + 1));
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = 32'd600;
        bus.dst_addr = 32'd700;
        bus.len      = LEN_W'(8);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_mem",  32'(bus.MEM),  32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.done || bus.MEM != 2'b00) bad++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(bad), 32'd0);
        chk("abort_w0", mem[700], 32'd3);
        chk("abort_w1", mem[701], 32'd6);
        chk("abort_w2_untouched", mem[702], 32'hA5A5_02BE);
`ifdef MEMCPY_CHECKSUM_EN
        chk("abort_checksum", bus.checksum, 32'd0);
`endif
        run_copy(32'd600, 32'd700, LEN_W'(8), 0, lat);
        chk("restart_latency", 32'(lat), 32'd17);
        chk("restart_last", mem[707], 32'd24);
        chk("restart_after", mem[708], 32'hA5A5_02C4);
`ifdef MEMCPY_CHECKSUM_EN
        chk("restart_checksum", bus.checksum, 32'h6C);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
